mem_bus_arbiter: RTL and testbench

- Sequences the CPU's single shared memory port between two requesters: the instruction-fetch path (PC-addressed word reads) and the data path (lw reads / sw writes at ALU-computed addresses).
- Each requester gets a req/ack handshake. The arbiter drives one registered memory transaction at a time and waits for `mem_ready`, with a timeout.
- Data requests have priority, with an anti-starvation limit for fetch.
- Sits between the CPU core and the memory model, replacing the direct `cpu_addr_bus`/`cpu_rd`/`cpu_wr` mux.

---
 rtl/mem_bus_arbiter_if.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch port, data port and shared memory bus seen by mem_bus_arbiter.
// master: the arbiter. slave: the CPU requesters plus the memory model.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Requester handshake: req is held with its address/data stable until the
    // one-cycle ack pulse; rdata/err are valid only while ack is high. The
    // requester drops req or presents a new transaction in the cycle after ack.
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        output mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        input  mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access: data has
// priority, fetch is guaranteed a slot after MAX_D_BURST data grants, with a timeout.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 16,
    parameter int MAX_D_BURST = 4
) (
    input  logic                mem_arb_clk,
    input  logic                mem_arb_rst,
    mem_bus_arbiter_if.master   bus,
    output logic [1:0]          dbg_state_o
);
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int BST_W = $clog2(MAX_D_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = data path, 0 = fetch path
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [BST_W-1:0]  burst_q, burst_d;
    logic              i_ack_q, i_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              i_err_q, i_err_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;

    logic grant_data, grant_fetch, misaligned, tmo_end;

    assign grant_data  = bus.d_req && (!bus.i_req || (burst_q < BST_W'(MAX_D_BURST)));
    assign grant_fetch = !grant_data && bus.i_req;
    assign misaligned  = bus.d_addr[1:0] != 2'b00;
    assign tmo_end     = tmo_q == TMO_W'(TIMEOUT - 1);

    always_ff @(posedge mem_arb_clk) begin
        if (mem_arb_rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            tmo_q       <= '0;
            burst_q     <= '0;
            i_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            tmo_q       <= tmo_d;
            burst_q     <= burst_d;
            i_ack_q     <= i_ack_d;
            i_rdata_q   <= i_rdata_d;
            i_err_q     <= i_err_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    state_d = misaligned ? ST_DONE : ST_BUSY;
                end else if (grant_fetch) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready || tmo_end) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        tmo_d       = tmo_q;
        burst_d     = burst_q;
        i_ack_d     = 1'b0;
        i_rdata_d   = '0;
        i_err_d     = 1'b0;
        d_ack_d     = 1'b0;
        d_rdata_d   = '0;
        d_err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    owner_d    = 1'b1;
                    we_d       = bus.d_we;
                    mem_addr_d = bus.d_addr;
                    tmo_d      = '0;
                    burst_d    = bus.i_req ? burst_q + BST_W'(1) : '0;
                    if (bus.d_we) begin
                        mem_wdata_d = bus.d_wdata;
                    end
                    // A misaligned access never reaches memory; it is answered directly.
                    if (misaligned) begin
                        mem_rd_d = 1'b0;
                        mem_wr_d = 1'b0;
                        d_ack_d  = 1'b1;
                        d_err_d  = 1'b1;
                    end else begin
                        mem_rd_d = !bus.d_we;
                        mem_wr_d = bus.d_we;
                    end
                end else if (grant_fetch) begin
                    owner_d    = 1'b0;
                    we_d       = 1'b0;
                    mem_addr_d = bus.i_addr;
                    mem_rd_d   = 1'b1;
                    mem_wr_d   = 1'b0;
                    tmo_d      = '0;
                    burst_d    = '0;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready || tmo_end) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (owner_q) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = !bus.mem_ready;
                        d_rdata_d = (bus.mem_ready && !we_q) ? bus.mem_rdata : '0;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_err_d   = !bus.mem_ready;
                        i_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a memory model with selectable latency, a response
// scoreboard per requester, and directed plus random traffic.
module tb_mem_bus_arbiter;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT     = 16;
    localparam int MAX_D_BURST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         n_vec = 0;
    int         n_bad = 0;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .MAX_D_BURST(MAX_D_BURST)
    ) dut (
        .mem_arb_clk(clk),
        .mem_arb_rst(rst),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // {err, rdata} expected per requester, in issue order
    logic [DATA_W:0]   i_exp_q[$];
    logic [DATA_W:0]   d_exp_q[$];
    logic [DATA_W-1:0] mem_arr[logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ref_mem[logic [ADDR_W-1:0]];
    logic              ack_log[$];
    logic              bus_we_log[$];
    logic [ADDR_W-1:0] bus_addr_log[$];
    logic [DATA_W-1:0] bus_wdata_log[$];

    bit mem_dead  = 1'b0;
    bit mem_noise = 1'b0;
    bit rand_lat  = 1'b0;
    int fixed_lat = 1;
    int wait_cnt  = 0;
    int cur_lat   = 1;
    int strobe_run = 0;
    int last_run   = 0;
    int i_ack_cnt  = 0;
    int d_ack_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return a ^ 32'h5A5A_3C3C;
    endfunction

    // memory model: answers a strobe after cur_lat wait cycles unless dead
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!bus.mem_rd && !bus.mem_wr) begin
                bus.mem_ready = mem_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.mem_rdata = $urandom;
                wait_cnt      = 0;
                cur_lat       = rand_lat ? $urandom_range(0, 4) : fixed_lat;
            end else if (mem_dead) begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
            end else if (wait_cnt == cur_lat) begin
                bus.mem_ready = 1'b1;
                if (bus.mem_rd) begin
                    bus.mem_rdata = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : pat(bus.mem_addr);
                end
                if (bus.mem_wr) begin
                    mem_arr[bus.mem_addr] = bus.mem_wdata;
                end
                wait_cnt++;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
                wait_cnt++;
            end
        end
    end

    // monitor: scoreboard pop on ack, strobe-run length and bus transaction log
    initial begin
        logic i_prev, d_prev;
        logic [DATA_W:0] e;
        i_prev = 1'b0;
        d_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_rd && bus.mem_wr) chk("strobe_excl", 1, 0);
            if (bus.mem_rd || bus.mem_wr) begin
                if (strobe_run == 0) begin
                    bus_we_log.push_back(bus.mem_wr);
                    bus_addr_log.push_back(bus.mem_addr);
                    bus_wdata_log.push_back(bus.mem_wdata);
                end
                strobe_run++;
            end else if (strobe_run != 0) begin
                last_run   = strobe_run;
                strobe_run = 0;
            end
            if (bus.i_ack && bus.d_ack) chk("ack_excl", 1, 0);
            if (bus.i_ack) begin
                i_ack_cnt++;
                ack_log.push_back(1'b0);
                if (i_prev) chk("i_ack_pulse", 1, 0);
                if (i_exp_q.size() == 0) chk("i_ack_unexp", 1, 0);
                else begin
                    e = i_exp_q.pop_front();
                    chk("i_resp", {bus.i_err, bus.i_rdata}, e);
                end
            end
            if (bus.d_ack) begin
                d_ack_cnt++;
                ack_log.push_back(1'b1);
                if (d_prev) chk("d_ack_pulse", 1, 0);
                if (d_exp_q.size() == 0) chk("d_ack_unexp", 1, 0);
                else begin
                    e = d_exp_q.pop_front();
                    chk("d_resp", {bus.d_err, bus.d_rdata}, e);
                end
            end
            i_prev = bus.i_ack;
            d_prev = bus.d_ack;
        end
    end

    task automatic fetch_op(input logic [ADDR_W-1:0] a, output int n);
        logic [DATA_W-1:0] v;
        v = mem_dead ? '0 : (ref_mem.exists(a) ? ref_mem[a] : pat(a));
        i_exp_q.push_back({mem_dead, v});
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.i_ack && n < 200);
        if (!bus.i_ack) chk("i_ack_wait", 0, 1);
        bus.i_req = 1'b0;
    endtask

    task automatic data_op(input logic [ADDR_W-1:0] a, input logic we,
                           input logic [DATA_W-1:0] wd, output int n);
        logic              err;
        logic [DATA_W-1:0] v;
        err = mem_dead || (a[1:0] != 2'b00);
        v   = (err || we) ? '0 : (ref_mem.exists(a) ? ref_mem[a] : pat(a));
        d_exp_q.push_back({err, v});
        if (we && !err) ref_mem[a] = wd;
        bus.d_req   = 1'b1;
        bus.d_addr  = a;
        bus.d_we    = we;
        bus.d_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.d_ack && n < 200);
        if (!bus.d_ack) chk("d_ack_wait", 0, 1);
        bus.d_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1);
    end

    initial begin
        int n, n1, n2, base_log, cnt0;
        logic [12:0] exp_ord;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        mem_arr[32'h0040_0000] = 32'h2008_0005;
        ref_mem[32'h0040_0000] = 32'h2008_0005;

        do_reset();
        chk("rst_state", dbg_state, 0);
        chk("rst_strobes", {bus.mem_rd, bus.mem_wr}, 0);
        chk("rst_acks", {bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);

        // single fetch, one wait cycle
        fetch_op(32'h0040_0000, n);
        @(negedge clk);
        chk("t1_lat", n, 3);
        chk("t1_rd_len", last_run, 2);
        chk("t1_addr", bus_addr_log[bus_addr_log.size()-1], 32'h0040_0000);
        chk("t1_we", bus_we_log[bus_we_log.size()-1], 0);
        chk("t1_idle", dbg_state, 0);

        // simultaneous requests: data first
        do_reset();
        base_log = bus_addr_log.size();
        ack_log.delete();
        fork
            data_op(32'h1001_0000, 1'b1, 32'hDEAD_BEEF, n1);
            fetch_op(32'h0040_0004, n2);
        join
        @(negedge clk);
        chk("t2_nlog", bus_addr_log.size() - base_log, 2);
        if (bus_addr_log.size() >= base_log + 2) begin
            chk("t2_first_we", bus_we_log[base_log], 1);
            chk("t2_first_addr", bus_addr_log[base_log], 32'h1001_0000);
            chk("t2_first_wdata", bus_wdata_log[base_log], 32'hDEAD_BEEF);
            chk("t2_second_we", bus_we_log[base_log+1], 0);
            chk("t2_second_addr", bus_addr_log[base_log+1], 32'h0040_0004);
        end
        data_op(32'h1001_0000, 1'b0, '0, n);

        // starvation limit: 10 data vs 3 fetch
        do_reset();
        ack_log.delete();
        exp_ord = 13'b1111011110110;
        fork
            begin
                for (int k = 0; k < 10; k++) data_op(32'h1001_0000 + 32'(4 * k), 1'b0, '0, n1);
            end
            begin
                for (int k = 0; k < 3; k++) fetch_op(32'h0040_0100 + 32'(4 * k), n2);
            end
        join
        @(negedge clk);
        chk("t3_nack", ack_log.size(), 13);
        for (int k = 0; k < 13; k++) begin
            if (k < ack_log.size()) chk($sformatf("t3_order%0d", k), ack_log[k], exp_ord[12-k]);
        end

        // timeout on fetch and on data write
        mem_dead = 1'b1;
        fetch_op(32'h0040_0008, n);
        @(negedge clk);
        chk("t4_i_lat", n, TIMEOUT + 1);
        chk("t4_i_rd_len", last_run, TIMEOUT);
        data_op(32'h1001_0040, 1'b1, 32'h1234_5678, n);
        @(negedge clk);
        chk("t4_d_wr_len", last_run, TIMEOUT);
        mem_dead = 1'b0;
        data_op(32'h1001_0040, 1'b0, '0, n);

        // misaligned data accesses never strobe memory
        base_log = bus_addr_log.size();
        data_op(32'h1001_0002, 1'b0, '0, n);
        chk("t5_rd_lat", n <= 2, 1);
        data_op(32'h1001_0001, 1'b1, 32'hCAFE_F00D, n);
        @(negedge clk);
        chk("t5_no_strobe", bus_addr_log.size() - base_log, 0);

        // fetch address low bits pass through untouched
        fetch_op(32'h0040_0006, n);
        @(negedge clk);
        chk("t5_fetch_addr", bus_addr_log[bus_addr_log.size()-1], 32'h0040_0006);

        // reset in the middle of a read
        mem_dead   = 1'b1;
        bus.i_addr = 32'h0040_0010;
        bus.i_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_rd && n < 20);
        chk("t6_started", bus.mem_rd, 1);
        repeat (3) @(negedge clk);
        cnt0      = i_ack_cnt + d_ack_cnt;
        rst       = 1'b1;
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("t6_strobes", {bus.mem_rd, bus.mem_wr}, 0);
        chk("t6_state", dbg_state, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_no_ack", i_ack_cnt + d_ack_cnt, cnt0);
        mem_dead = 1'b0;
        fetch_op(32'h0040_0010, n);
        chk("t6_reissue_lat", n, 3);

        // random mixed traffic with variable latency and ready noise outside BUSY
        mem_noise = 1'b1;
        rand_lat  = 1'b1;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    logic [ADDR_W-1:0] a;
                    a = 32'h1001_0000 + 32'(4 * $urandom_range(0, 7));
                    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                    data_op(a, 1'($urandom_range(0, 1)), $urandom, n1);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    fetch_op(32'h0040_0000 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3)), n2);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join
        mem_noise = 1'b0;
        rand_lat  = 1'b0;
        for (int k = 0; k < 8; k++) data_op(32'h1001_0000 + 32'(4 * k), 1'b0, '0, n);
        repeat (3) @(negedge clk);
        chk("i_q_empty", i_exp_q.size(), 0);
        chk("d_q_empty", d_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
